// File: rtl/crc8_frame_ctrl.sv
// Streaming CRC-8 (poly 0x07, MSB-first) framer: forwards payload through one output
// register and appends the CRC byte. Optional receive-check mode: CRC8_FRAME_CTRL_CHECK_EN.
module crc8_frame_ctrl #(
    parameter logic [7:0] INIT    = 8'h00,
    parameter logic [7:0] XOR_OUT = 8'h00,
    parameter int         CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [7:0]       m_data,
    output logic             m_last,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt,
`ifdef CRC8_FRAME_CTRL_CHECK_EN
    input  logic             check_mode,
    output logic             crc_ok,
    output logic             crc_bad,
`endif
    output logic             error
);

    typedef enum logic [1:0] {IDLE, DATA, APPEND} state_t;

    state_t           state_q, state_d;
    logic [7:0]       crc_q, crc_d;
    logic [7:0]       m_data_q, m_data_d;
    logic             m_valid_q, m_valid_d;
    logic             m_last_q, m_last_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             error_q, error_d;
    logic             pend_q, pend_d;
    logic             free;
    logic             accept;
    logic [7:0]       crc_base;
`ifdef CRC8_FRAME_CTRL_CHECK_EN
    logic             check_q, check_d;
    logic             crc_ok_q, crc_ok_d;
    logic             crc_bad_q, crc_bad_d;
    logic             chk_now;
    logic             crc_match;
`endif

    // Byte-parallel form of eight MSB-first shifts of (c ^ d) through x^8+x^2+x+1.
    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] x;
        logic [7:0] n;
        x    = c ^ d;
        n[0] = x[0] ^ x[6] ^ x[7];
        n[1] = x[0] ^ x[1] ^ x[6];
        n[2] = x[0] ^ x[1] ^ x[2] ^ x[6];
        n[3] = x[1] ^ x[2] ^ x[3] ^ x[7];
        n[4] = x[2] ^ x[3] ^ x[4];
        n[5] = x[3] ^ x[4] ^ x[5];
        n[6] = x[4] ^ x[5] ^ x[6];
        n[7] = x[5] ^ x[6] ^ x[7];
        return n;
    endfunction

    assign free     = !m_valid_q || m_ready;
    assign s_ready  = free && (state_q != APPEND);
    assign accept   = s_valid && s_ready;
    assign crc_base = (state_q == IDLE) ? INIT : crc_q;

`ifdef CRC8_FRAME_CTRL_CHECK_EN
    // Mode is latched on the first byte so a mid-frame change of check_mode is ignored.
    assign chk_now   = (state_q == IDLE) ? check_mode : check_q;
    assign crc_match = (s_data == (crc_base ^ XOR_OUT));
`endif

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        frame_cnt_d = frame_cnt_q;
        // A byte offered while stalled and then withdrawn is a producer protocol violation.
        error_d     = error_q | (pend_q && !s_valid);
        pend_d      = s_valid && !s_ready && (state_q != APPEND);
`ifdef CRC8_FRAME_CTRL_CHECK_EN
        check_d     = check_q;
        crc_ok_d    = 1'b0;
        crc_bad_d   = 1'b0;
`endif
        if (m_ready) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            IDLE, DATA: begin
                if (accept) begin
                    m_data_d  = s_data;
                    m_last_d  = 1'b0;
                    m_valid_d = 1'b1;
                    crc_d     = crc8_step(crc_base, s_data);
                    state_d   = s_last ? APPEND : DATA;
`ifdef CRC8_FRAME_CTRL_CHECK_EN
                    if (state_q == IDLE) begin
                        check_d = check_mode;
                    end
                    if (chk_now && s_last) begin
                        m_last_d    = 1'b1;
                        crc_d       = INIT;
                        state_d     = IDLE;
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                        crc_ok_d    = crc_match;
                        crc_bad_d   = !crc_match;
                    end
`endif
                end
            end
            APPEND: begin
                if (free) begin
                    m_data_d    = crc_q ^ XOR_OUT;
                    m_last_d    = 1'b1;
                    m_valid_d   = 1'b1;
                    crc_d       = INIT;
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            crc_q       <= INIT;
            m_data_q    <= 8'h00;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            frame_cnt_q <= '0;
            error_q     <= 1'b0;
            pend_q      <= 1'b0;
`ifdef CRC8_FRAME_CTRL_CHECK_EN
            check_q     <= 1'b0;
            crc_ok_q    <= 1'b0;
            crc_bad_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            frame_cnt_q <= frame_cnt_d;
            error_q     <= error_d;
            pend_q      <= pend_d;
`ifdef CRC8_FRAME_CTRL_CHECK_EN
            check_q     <= check_d;
            crc_ok_q    <= crc_ok_d;
            crc_bad_q   <= crc_bad_d;
`endif
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_last    = m_last_q;
    assign busy      = (state_q != IDLE);
    assign frame_cnt = frame_cnt_q;
    assign error     = error_q;
`ifdef CRC8_FRAME_CTRL_CHECK_EN
    assign crc_ok    = crc_ok_q;
    assign crc_bad   = crc_bad_q;
`endif

endmodule

// File: tb/tb_crc8_frame_ctrl.sv
// Scoreboard bench for crc8_frame_ctrl; a second instance covers INIT/XOR_OUT = 0xFF.
module tb_crc8_frame_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        s_valid, s_ready, s_last;
    logic [7:0]  s_data;
    logic        m_valid, m_ready, m_last, busy, error;
    logic [7:0]  m_data;
    logic [15:0] frame_cnt;
`ifdef CRC8_FRAME_CTRL_CHECK_EN
    logic        check_mode, crc_ok, crc_bad;
    logic        check_mode2, crc_ok2, crc_bad2;
`endif

    logic        s2_valid, s2_ready, s2_last;
    logic [7:0]  s2_data;
    logic        m2_valid, m2_ready, m2_last, busy2, error2;
    logic [7:0]  m2_data;
    logic [15:0] frame_cnt2;

    crc8_frame_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .frame_cnt(frame_cnt),
`ifdef CRC8_FRAME_CTRL_CHECK_EN
        .check_mode(check_mode), .crc_ok(crc_ok), .crc_bad(crc_bad),
`endif
        .error(error)
    );

    crc8_frame_ctrl #(.INIT(8'hFF), .XOR_OUT(8'hFF), .CNT_W(16)) dut_x (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s2_valid), .s_ready(s2_ready), .s_data(s2_data), .s_last(s2_last),
        .m_valid(m2_valid), .m_ready(m2_ready), .m_data(m2_data), .m_last(m2_last),
        .busy(busy2), .frame_cnt(frame_cnt2),
`ifdef CRC8_FRAME_CTRL_CHECK_EN
        .check_mode(check_mode2), .crc_ok(crc_ok2), .crc_bad(crc_bad2),
`endif
        .error(error2)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         rdy_mode = 0;   // 0 fixed, 1 toggle, 2 random
    logic       prev_stall = 1'b0;
    logic [7:0] prev_d = 8'h00;
    logic       prev_l = 1'b0;

    // Serial reference: one polynomial shift per bit.
    function automatic logic [7:0] ref_crc(input logic [7:0] init, input logic [7:0] b[$]);
        logic [7:0] c;
        c = init;
        foreach (b[i]) begin
            c = c ^ b[i];
            for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    // One clock: monitor at negedge, return s_ready seen there, inputs change #1 after posedge.
    task automatic tick(output logic rdy);
        exp_t e;
        @(negedge clk);
        rdy = s_ready;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_checks++;
                if (m_valid !== 1'b1 || m_data !== prev_d || m_last !== prev_l) begin
                    n_fail++;
                    $display("FAIL hold: got v=%b d=%h l=%b want v=1 d=%h l=%b", m_valid, m_data, m_last, prev_d, prev_l);
                end
            end
            if (m_valid && !m_ready) begin
                n_checks++;
                if (s_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_s_ready: got %b want 0", s_ready);
                end
            end
            if (m_valid && m_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_byte: got d=%h l=%b want nothing", m_data, m_last);
                end else begin
                    e = sb.pop_front();
                    if (m_data !== e.d || m_last !== e.l) begin
                        n_fail++;
                        $display("FAIL out_byte: got d=%h l=%b want d=%h l=%b", m_data, m_last, e.d, e.l);
                    end
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_d     = m_data;
            prev_l     = m_last;
        end
        @(posedge clk);
        #1;
        if (rdy_mode == 1) m_ready = ~m_ready;
        else if (rdy_mode == 2) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, input logic exp_last,
                             output int stalls);
        logic r;
        logic done;
        s_valid = 1'b1; s_data = d; s_last = last;
        stalls = 0; done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            tick(r);
            if (r) done = 1'b1;
            else stalls++;
        end
        if (done) begin
            sb.push_back('{d: d, l: exp_last});
        end else begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: got no accept want accept of %h", d);
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b[$], input logic [7:0] crc_exp);
        int st;
        foreach (b[i]) send_byte(b[i], (i == b.size() - 1), 1'b0, st);
        sb.push_back('{d: crc_exp, l: 1'b1});
    endtask

    task automatic wait_drain();
        logic r;
        for (int i = 0; i < 400 && sb.size() != 0; i++) tick(r);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        rdy_mode = 0; m_ready = 1'b1;
        repeat (3) tick(r);
    endtask

    task automatic do_reset();
        logic r;
        rst_n = 1'b0; s_valid = 1'b0; s2_valid = 1'b0; m_ready = 1'b1; rdy_mode = 0;
        sb.delete();
        tick(r); tick(r);
        rst_n = 1'b1;
    endtask

    task automatic chk_cnt(input logic [15:0] want);
        n_checks++;
        if (frame_cnt !== want) begin
            n_fail++;
            $display("FAIL frame_cnt: got %0d want %0d", frame_cnt, want);
        end
    endtask

    function automatic void load_123(ref logic [7:0] q[$]);
        q.delete();
        for (int i = 0; i < 9; i++) q.push_back(8'h31 + 8'(i));
    endfunction

    task automatic test_reset();
        logic r;
        rst_n = 1'b0;
        tick(r);
        n_checks++;
        if (m_valid !== 1'b0 || m_data !== 8'h00 || m_last !== 1'b0 || busy !== 1'b0 ||
            frame_cnt !== 16'd0 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_vals: got v=%b d=%h l=%b busy=%b cnt=%0d err=%b want all 0",
                     m_valid, m_data, m_last, busy, frame_cnt, error);
        end
        rst_n = 1'b1;
        tick(r);
        n_checks++;
        if (r !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_s_ready: got %b want 1", r);
        end
    endtask

    task automatic test_basic();
        logic [7:0] q[$];
        load_123(q);
        send_frame(q, 8'hF4);
        wait_drain();
        chk_cnt(16'd1);
    endtask

    task automatic test_back_to_back();
        int   st;
        logic r;
        send_byte(8'h01, 1'b1, 1'b0, st);
        sb.push_back('{d: 8'h07, l: 1'b1});
        n_checks++;
        if (st != 0) begin n_fail++; $display("FAIL b2b_stall0: got %0d want 0", st); end
        send_byte(8'hFF, 1'b1, 1'b0, st);
        sb.push_back('{d: 8'hF3, l: 1'b1});
        n_checks++;
        if (st != 1) begin n_fail++; $display("FAIL b2b_stall1: got %0d want 1", st); end
        tick(r);
        n_checks++;
        if (r !== 1'b0) begin n_fail++; $display("FAIL append_ready: got %b want 0", r); end
        tick(r);
        n_checks++;
        if (r !== 1'b1) begin n_fail++; $display("FAIL post_append_ready: got %b want 1", r); end
        wait_drain();
        chk_cnt(16'd3);
    endtask

    task automatic test_backpressure();
        logic [7:0] q[$];
        load_123(q);
        m_ready = 1'b0; rdy_mode = 1;
        send_frame(q, 8'hF4);
        wait_drain();
        chk_cnt(16'd4);
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        int n;
        n = $urandom_range(5, 12);
        for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
        rdy_mode = 2;
        send_frame(q, ref_crc(8'h00, q));
        wait_drain();
        chk_cnt(16'd5);
    endtask

    task automatic test_xor_init();
        logic r;
        s2_valid = 1'b1; s2_data = 8'h00; s2_last = 1'b1;
        n_checks++;
        if (s2_ready !== 1'b1) begin n_fail++; $display("FAIL x_ready: got %b want 1", s2_ready); end
        tick(r);
        s2_valid = 1'b0; s2_last = 1'b0;
        n_checks++;
        if (m2_valid !== 1'b1 || m2_data !== 8'h00 || m2_last !== 1'b0) begin
            n_fail++;
            $display("FAIL x_payload: got v=%b d=%h l=%b want v=1 d=00 l=0", m2_valid, m2_data, m2_last);
        end
        tick(r);
        n_checks++;
        if (m2_valid !== 1'b1 || m2_data !== 8'h0C || m2_last !== 1'b1 || frame_cnt2 !== 16'd1) begin
            n_fail++;
            $display("FAIL x_crc: got v=%b d=%h l=%b cnt=%0d want v=1 d=0c l=1 cnt=1",
                     m2_valid, m2_data, m2_last, frame_cnt2);
        end
        tick(r);
        n_checks++;
        if (m2_valid !== 1'b0) begin n_fail++; $display("FAIL x_idle: got %b want 0", m2_valid); end
    endtask

    task automatic test_error();
        int   st;
        logic r;
        m_ready = 1'b0;
        send_byte(8'h55, 1'b0, 1'b0, st);
        n_checks++;
        if (error !== 1'b0) begin n_fail++; $display("FAIL err_early: got %b want 0", error); end
        s_valid = 1'b1; s_data = 8'h66;
        tick(r);
        s_valid = 1'b0;
        tick(r);
        n_checks++;
        if (error !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", error); end
        tick(r);
        n_checks++;
        if (error !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", error); end
        do_reset();
        n_checks++;
        if (error !== 1'b0 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: got err=%b v=%b want 0 0", error, m_valid);
        end
    endtask

    task automatic test_reset_midframe();
        int   st;
        logic r;
        logic [7:0] q[$];
        for (int i = 0; i < 4; i++) send_byte(8'h31 + 8'(i), 1'b0, 1'b0, st);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || m_last !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got v=%b busy=%b l=%b want 0 0 0", m_valid, busy, m_last);
        end
        sb.delete();
        tick(r);
        rst_n = 1'b1;
        load_123(q);
        send_frame(q, 8'hF4);
        wait_drain();
        chk_cnt(16'd1);
        n_checks++;
        if (error !== 1'b0) begin n_fail++; $display("FAIL mid_error: got %b want 0", error); end
    endtask

`ifdef CRC8_FRAME_CTRL_CHECK_EN
    task automatic test_check();
        int   st;
        logic [7:0] q[$];
        do_reset();
        load_123(q);
        for (int f = 0; f < 2; f++) begin
            check_mode = 1'b1;
            foreach (q[i]) begin
                send_byte(q[i], 1'b0, 1'b0, st);
                check_mode = 1'b0;
                if (f == 1 && i == 0) begin
                    n_checks++;
                    if (crc_ok !== 1'b0 || crc_bad !== 1'b0) begin
                        n_fail++;
                        $display("FAIL ok_pulse_len: got ok=%b bad=%b want 0 0", crc_ok, crc_bad);
                    end
                end
            end
            send_byte((f == 0) ? 8'hF4 : 8'hF5, 1'b1, 1'b1, st);
            n_checks++;
            if (crc_ok !== (f == 0) || crc_bad !== (f == 1)) begin
                n_fail++;
                $display("FAIL chk_result%0d: got ok=%b bad=%b want ok=%b bad=%b",
                         f, crc_ok, crc_bad, (f == 0), (f == 1));
            end
        end
        check_mode = 1'b1;
        send_byte(8'h00, 1'b1, 1'b1, st);
        check_mode = 1'b0;
        n_checks++;
        if (crc_ok !== 1'b1 || crc_bad !== 1'b0) begin
            n_fail++;
            $display("FAIL chk_single: got ok=%b bad=%b want 1 0", crc_ok, crc_bad);
        end
        wait_drain();
        chk_cnt(16'd3);
    endtask
`endif

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; m_ready = 1'b1;
        s2_valid = 1'b0; s2_data = 8'h00; s2_last = 1'b0; m2_ready = 1'b1;
`ifdef CRC8_FRAME_CTRL_CHECK_EN
        check_mode = 1'b0; check_mode2 = 1'b0;
`endif
        #2;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_xor_init();
        test_error();
        test_reset_midframe();
`ifdef CRC8_FRAME_CTRL_CHECK_EN
        test_check();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish want finish before 500000");
        $fatal(1, "timeout");
    end

endmodule
